// File: rtl/sound_pkg.sv
// Shared definitions for the timed sound units: widths, tone FSM states and
// the note-to-divider scaling helper.
package sound_pkg;

    localparam int unsigned PRESCALE_W = 10;
    localparam int unsigned PHASE_W    = 8;
    localparam int unsigned OCT_W      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tone_state_t;

    localparam logic [PHASE_W-1:0] MIDSCALE = 8'h80;

    // Octave shift raises pitch; a non-zero note never collapses into a rest.
    function automatic logic [PRESCALE_W-1:0] scale_prescale(
        input logic [PRESCALE_W-1:0] psv,
        input logic [OCT_W-1:0]      oct
    );
        logic [PRESCALE_W-1:0] s;
        s = psv >> oct;
        if ((psv != '0) && (s == '0)) begin
            s = PRESCALE_W'(1);
        end
        return s;
    endfunction

endpackage

// File: rtl/tone_waveform_generator_if.sv
// Note request channel between the sound sequencer (master) and the tone
// generator (slave).
interface tone_waveform_generator_if;
    import sound_pkg::*;

    logic [PRESCALE_W-1:0] preScaleValue;
    logic [OCT_W-1:0]      octave;
    logic                  note_valid;
    logic                  note_ready;

    modport master (
        output preScaleValue,
        output octave,
        output note_valid,
        input  note_ready
    );

    modport slave (
        input  preScaleValue,
        input  octave,
        input  note_valid,
        output note_ready
    );

endinterface

// File: rtl/tone_waveform_generator_prescale_counter.sv
// Divide counter: counts 0..limit-1 while running and pulses step on the
// terminal count. Held at zero while clear is asserted.
module prescale_counter
    import sound_pkg::*;
#(
    parameter int unsigned W = PRESCALE_W
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clear_i,
    input  logic         run_i,
    input  logic [W-1:0] limit_i,
    output logic         step_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign step_o = run_i && (cnt_q == (limit_i - W'(1)));

    // Next count: clear wins, otherwise advance and roll over on step.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = step_o ? '0 : (cnt_q + W'(1));
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_waveform_generator.sv
// Tone generator: turns a per-note prescale value into a 256-step sawtooth /
// square wave. Note changes queue in a one-deep pending slot and take effect
// only at the period wrap, so the waveform never glitches mid-period.
module tone_waveform_generator
    import sound_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      enable,
    tone_waveform_generator_if.slave  note_if,
    output logic [PHASE_W-1:0]        sample,
    output logic                      square_out,
    output logic                      period_tick
);

    tone_state_t           state_q,    state_d;
    logic [PHASE_W-1:0]    phase_q,    phase_d;
    logic [PRESCALE_W-1:0] active_q,   active_d;
    logic                  pend_v_q,   pend_v_d;
    logic [PRESCALE_W-1:0] pend_val_q, pend_val_d;
    logic [PHASE_W-1:0]    sample_q,   sample_d;
    logic                  square_q,   square_d;
    logic                  tick_q,     tick_d;

    logic                  accept;
    logic                  step;
    logic                  wrap;
    logic                  div_run;
    logic [PRESCALE_W-1:0] scaled;

    // Ready depends on the live enable so a mute blocks the very same cycle.
    assign note_if.note_ready = enable && ((state_q == IDLE) || !pend_v_q);
    assign accept             = note_if.note_valid && note_if.note_ready;
    assign scaled             = scale_prescale(note_if.preScaleValue, note_if.octave);
    assign div_run            = enable && (state_q == RUN);
    assign wrap               = step && (phase_q == '1);

    prescale_counter #(
        .W (PRESCALE_W)
    ) u_div (
        .clk     (clk),
        .resetN  (resetN),
        .clear_i (!div_run),
        .run_i   (div_run),
        .limit_i (active_q),
        .step_o  (step)
    );

    // Note FSM, pending slot, phase advance and registered output values.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        active_d   = active_q;
        pend_v_d   = pend_v_q;
        pend_val_d = pend_val_q;
        tick_d     = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            phase_d  = '0;
            pend_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (scaled != '0)) begin
                        state_d  = RUN;
                        active_d = scaled;
                        phase_d  = '0;
                    end
                end
                RUN: begin
                    if (step) begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                    // Wrap consumes the old pending note before a coincident
                    // accept refills the slot for the following period.
                    if (wrap) begin
                        tick_d = 1'b1;
                        if (pend_v_q) begin
                            pend_v_d = 1'b0;
                            if (pend_val_q == '0) begin
                                state_d = IDLE;
                            end else begin
                                active_d = pend_val_q;
                            end
                        end
                    end
                    if (accept) begin
                        pend_v_d   = 1'b1;
                        pend_val_d = scaled;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == RUN) begin
            sample_d = phase_d;
            square_d = phase_d[PHASE_W-1];
        end else begin
            sample_d = MIDSCALE;
            square_d = 1'b0;
        end
    end

    // State and output registers; reset gives immediate silence.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            active_q   <= '0;
            pend_v_q   <= 1'b0;
            pend_val_q <= '0;
            sample_q   <= MIDSCALE;
            square_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            active_q   <= active_d;
            pend_v_q   <= pend_v_d;
            pend_val_q <= pend_val_d;
            sample_q   <= sample_d;
            square_q   <= square_d;
            tick_q     <= tick_d;
        end
    end

    assign sample      = sample_q;
    assign square_out  = square_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_tone_waveform_generator.sv
// Randomised scoreboard bench for tone_waveform_generator. The reference
// model describes the waveform as a function of elapsed time since the note
// started: phase = floor(elapsed / divider) mod 256, wrap every 256*divider.
module tb_tone_waveform_generator;
    import sound_pkg::*;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] sample;
    logic       square_out;
    logic       period_tick;

    tone_waveform_generator_if nif ();

    tone_waveform_generator dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .note_if     (nif),
        .sample      (sample),
        .square_out  (square_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ticks_seen = 0;

    typedef struct {
        int s;
        bit sq;
        bit tk;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit     m_run    = 1'b0;
    bit     m_pend   = 1'b0;
    int     m_active = 0;
    int     m_pval   = 0;
    longint m_cyc    = 0;
    longint m_start  = 0;

    function automatic int ref_scale(int psv, int oct);
        int s;
        s = psv / (1 << oct);
        if (psv != 0 && s == 0) s = 1;
        return s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Model: predict the outputs after each clock edge and queue them.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_run    = 1'b0;
            m_pend   = 1'b0;
            m_active = 0;
            m_cyc    = 0;
            m_start  = 0;
        end else begin : model_step
            exp_t   e;
            bit     acc;
            int     sc;
            longint el;
            m_cyc++;
            acc  = nif.note_valid && enable && (!m_run || !m_pend);
            sc   = ref_scale(int'(nif.preScaleValue), int'(nif.octave));
            e.tk = 1'b0;
            if (!enable) begin
                m_run  = 1'b0;
                m_pend = 1'b0;
            end else if (!m_run) begin
                if (acc && sc != 0) begin
                    m_run    = 1'b1;
                    m_active = sc;
                    m_start  = m_cyc;
                end
            end else begin
                if (m_cyc - m_start == longint'(256 * m_active)) begin
                    e.tk    = 1'b1;
                    m_start = m_cyc;
                    if (m_pend) begin
                        m_pend = 1'b0;
                        if (m_pval == 0) m_run = 1'b0;
                        else m_active = m_pval;
                    end
                end
                if (acc) begin
                    m_pend = 1'b1;
                    m_pval = sc;
                end
            end
            if (m_run) begin
                el  = m_cyc - m_start;
                e.s = int'((el / m_active) % 256);
            end else begin
                e.s = 128;
            end
            e.sq = m_run && (e.s >= 128);
            sb.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the queued prediction mid-cycle.
    always @(negedge clk) begin
        if (resetN && sb.size() > 0) begin : mon
            exp_t e;
            e = sb.pop_front();
            if (e.tk) ticks_seen++;
            check("sample", 32'(sample), 32'(e.s));
            check("square_out", 32'(square_out), 32'(e.sq));
            check("period_tick", 32'(period_tick), 32'(e.tk));
            check("note_ready", 32'(nif.note_ready), 32'(enable && (!m_run || !m_pend)));
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int psv, int oct);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        nif.note_valid    = 1'b1;
        nif.preScaleValue = PRESCALE_W'(psv);
        nif.octave        = OCT_W'(oct);
        while (!got && n < 20000) begin
            @(negedge clk);
            got = nif.note_ready;
            @(posedge clk);
            #1;
            n++;
        end
        nif.note_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake expected note_ready within 20000 cycles");
        end
    endtask

    task automatic mute(int n);
        enable = 1'b0;
        idle(n);
        enable = 1'b1;
    endtask

    initial begin
        nif.note_valid    = 1'b0;
        nif.preScaleValue = '0;
        nif.octave        = '0;

        // Reset state
        #12;
        check("reset_sample", 32'(sample), 32'd128);
        check("reset_square", 32'(square_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        check("reset_ready", 32'(nif.note_ready), 32'd1);
        @(negedge clk);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Smallest divider after octave shift: 3 >> 3 clamps to 1
        send(3, 3);
        idle(600);

        // Glitch-free change: queued note waits for the wrap
        send(12, 0);
        idle(500);
        send(7, 0);
        send(9, 1);
        idle(2500);

        // Rest while running, then rest while idle
        send(0, 0);
        idle(3000);
        send(0, 2);
        idle(20);

        // Mute with a pending note
        send(10, 0);
        idle(50);
        send(6, 0);
        idle(20);
        mute(1);
        idle(3000);

        // Reset in the middle of a note
        send(5, 0);
        idle(300);
        @(negedge clk);
        #1 resetN = 1'b0;
        #1;
        check("midrun_reset_sample", 32'(sample), 32'd128);
        check("midrun_reset_square", 32'(square_out), 32'd0);
        check("midrun_reset_tick", 32'(period_tick), 32'd0);
        check("midrun_reset_ready", 32'(nif.note_ready), 32'd1);
        @(negedge clk);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic
        for (int k = 0; k < 30; k++) begin
            int act;
            act = int'($urandom_range(0, 11));
            if (act == 0) begin
                mute(int'($urandom_range(1, 3)));
            end else if (act <= 2) begin
                send(0, int'($urandom_range(0, 3)));
            end else begin
                send(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
            end
            idle(int'($urandom_range(0, 900)));
        end

        idle(3);
        check("ticks_observed", 32'(ticks_seen > 3), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
